// File: rtl/spi_pixel_sender.sv
// Streams a frame of pixels from a synchronous-read pixel memory out over a
// write-only SPI link, MSB first, with back-to-back pixels and no inter-pixel gap.
module spi_pixel_sender #(
  parameter int BITS_PER_PIXEL = 32,
  parameter int PIXELS         = 2048,
  parameter int CLK_DIV        = 2,
  localparam int AW            = (PIXELS > 1) ? $clog2(PIXELS) : 1
) (
  input  logic                      clk,
  input  logic                      reset,
  input  logic                      start,
  output logic                      busy,
  output logic                      done,
  output logic [AW-1:0]             pixel_addr,
  input  logic [BITS_PER_PIXEL-1:0] pixel_data,
  output logic                      spi_clk,
  output logic                      spi_mosi
);

  localparam int BW = $clog2(BITS_PER_PIXEL);
  localparam int DW = $clog2(CLK_DIV);
  localparam logic [BW-1:0] BIT_LAST = BW'(BITS_PER_PIXEL - 1);
  localparam logic [AW-1:0] PIX_LAST = AW'(PIXELS - 1);
  localparam logic [DW-1:0] DIV_LAST = DW'(CLK_DIV - 1);
  localparam logic [DW-1:0] DIV_ONE  = DW'(1);

  typedef enum logic [2:0] {
    IDLE,
    FETCH,
    LOAD,
    SHIFT_LOW,
    SHIFT_HIGH
  } state_t;

  state_t                    state;
  logic [BITS_PER_PIXEL-1:0] shift_reg;
  logic [BITS_PER_PIXEL-1:0] prefetch;
  logic [BITS_PER_PIXEL-1:0] next_word;
  logic [BW-1:0]             bit_cnt;
  logic [AW-1:0]             pix_cnt;
  logic [DW-1:0]             div_cnt;
  logic                      div_end;
  logic                      last_bit;
  logic                      last_pix;

  assign div_end  = (div_cnt == DIV_LAST);
  assign last_bit = (bit_cnt == '0);
  assign last_pix = (pix_cnt == PIX_LAST);

  // Read data lands on the second SHIFT_HIGH cycle; with CLK_DIV=2 that is also
  // the cycle the next pixel must load, so bypass the prefetch register then.
  assign next_word = (div_cnt == DIV_ONE) ? pixel_data : prefetch;

  // NOTE: every state register uses <= so all updates see pre-edge values;
  // all of them, shift and prefetch included, are cleared by reset.
  always_ff @(posedge clk) begin
    if (reset) begin
      state      <= IDLE;
      busy       <= 1'b0;
      done       <= 1'b0;
      pixel_addr <= '0;
      spi_clk    <= 1'b0;
      spi_mosi   <= 1'b0;
      shift_reg  <= '0;
      prefetch   <= '0;
      bit_cnt    <= '0;
      pix_cnt    <= '0;
      div_cnt    <= '0;
    end else begin
      done <= 1'b0;
      case (state)
        IDLE: begin
          if (start) begin
            busy       <= 1'b1;
            pixel_addr <= '0;
            pix_cnt    <= '0;
            bit_cnt    <= BIT_LAST;
            state      <= FETCH;
          end
        end
        FETCH: state <= LOAD;
        LOAD: begin
          shift_reg <= pixel_data;
          spi_mosi  <= pixel_data[BITS_PER_PIXEL-1];
          spi_clk   <= 1'b0;
          div_cnt   <= '0;
          state     <= SHIFT_LOW;
        end
        SHIFT_LOW: begin
          if (div_end) begin
            div_cnt <= '0;
            spi_clk <= 1'b1;
            state   <= SHIFT_HIGH;
            if (last_bit && !last_pix) pixel_addr <= pixel_addr + AW'(1);
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        SHIFT_HIGH: begin
          if (last_bit && div_cnt == DIV_ONE) prefetch <= pixel_data;
          if (div_end) begin
            div_cnt <= '0;
            spi_clk <= 1'b0;
            if (!last_bit) begin
              shift_reg <= shift_reg << 1;
              spi_mosi  <= shift_reg[BITS_PER_PIXEL-2];
              bit_cnt   <= bit_cnt - BW'(1);
              state     <= SHIFT_LOW;
            end else if (!last_pix) begin
              shift_reg <= next_word;
              spi_mosi  <= next_word[BITS_PER_PIXEL-1];
              bit_cnt   <= BIT_LAST;
              pix_cnt   <= pix_cnt + AW'(1);
              state     <= SHIFT_LOW;
            end else begin
              spi_mosi <= 1'b0;
              busy     <= 1'b0;
              done     <= 1'b1;
              state    <= IDLE;
            end
          end else begin
            div_cnt <= div_cnt + DW'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
